// File: rtl/serial_comp_ctrl.sv
// Nibble-serial RV32I branch comparator: one 4-bit compare slice reused WIDTH/4 times LSB->MSB.
// Optional build macro CMP_EARLY_EQ_EN: bypass the serial walk when the operands are equal at start.

module fourbits_comp (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ieq_i,
  input  logic       ilt_i,
  input  logic       ibt_i,
  output logic       oeq_o,
  output logic       olt_o,
  output logic       obt_o
);
  logic nib_eq;

  // A difference in this (more significant) nibble overrides the lower-nibble cascade.
  assign nib_eq = (a_i == b_i);
  assign oeq_o  = ieq_i & nib_eq;
  assign olt_o  = (a_i < b_i) | (nib_eq & ilt_i);
  assign obt_o  = (a_i > b_i) | (nib_eq & ibt_i);
endmodule

module serial_comp_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       funct3,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic             taken
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_EQ
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       f3_q, f3_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             ceq_q, ceq_d;
  logic             clt_q, clt_d;
  logic             cgt_q, cgt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             taken_q, taken_d;
  logic             done_q, done_d;

  logic             last_nib;
  logic             early_eq;
  logic [3:0]       nib_a, nib_b;
  logic             s_eq, s_lt, s_gt;

  function automatic logic branch_taken(input logic [2:0] f3, input logic e, input logic l);
    case (f3)
      3'b000:         return e;
      3'b001:         return ~e;
      3'b100, 3'b110: return l;
      3'b101, 3'b111: return ~l;
      default:        return 1'b0;
    endcase
  endfunction

`ifdef CMP_EARLY_EQ_EN
  assign early_eq = (a == b);
`else
  assign early_eq = 1'b0;
`endif

  assign last_nib = (idx_q == IW'(NIB - 1));

  // Signed compare: flipping the sign bit of the top nibble maps two's complement onto unsigned order.
  always_comb begin
    nib_a = a_q[{idx_q, 2'b00} +: 4];
    nib_b = b_q[{idx_q, 2'b00} +: 4];
    if (last_nib && (f3_q[2:1] == 2'b10)) begin
      nib_a[3] = ~nib_a[3];
      nib_b[3] = ~nib_b[3];
    end
  end

  fourbits_comp u_slice (
    .a_i   (nib_a),
    .b_i   (nib_b),
    .ieq_i (ceq_q),
    .ilt_i (clt_q),
    .ibt_i (cgt_q),
    .oeq_o (s_eq),
    .olt_o (s_lt),
    .obt_o (s_gt)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f3_d    = f3_q;
    idx_d   = idx_q;
    ceq_d   = ceq_q;
    clt_d   = clt_q;
    cgt_d   = cgt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    taken_d = taken_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          f3_d    = funct3;
          idx_d   = '0;
          ceq_d   = 1'b1;
          clt_d   = 1'b0;
          cgt_d   = 1'b0;
          state_d = early_eq ? S_EQ : S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        ceq_d = s_eq;
        clt_d = s_lt;
        cgt_d = s_gt;
        idx_d = idx_q + IW'(1);
        if (last_nib) begin
          idx_d   = '0;
          eq_d    = s_eq;
          lt_d    = s_lt;
          gt_d    = s_gt;
          taken_d = branch_taken(f3_q, s_eq, s_lt);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_EQ: begin
        eq_d    = 1'b1;
        lt_d    = 1'b0;
        gt_d    = 1'b0;
        taken_d = branch_taken(f3_q, 1'b1, 1'b0);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f3_q    <= '0;
      idx_q   <= '0;
      ceq_q   <= 1'b1;
      clt_q   <= 1'b0;
      cgt_q   <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      taken_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f3_q    <= f3_d;
      idx_q   <= idx_d;
      ceq_q   <= ceq_d;
      clt_q   <= clt_d;
      cgt_q   <= cgt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      taken_q <= taken_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign done  = done_q;
  assign eq    = eq_q;
  assign lt    = lt_q;
  assign gt    = gt_q;
  assign taken = taken_q;
endmodule
